bpu_update_sched: RTL and testbench
===================================

// Module: bpu_update_sched
// PURPOSE
//  Schedules all writes into the next-PC predictor tables (BTB, RAS, CPHT).
//  Buffers up to two resolved-branch update packets per cycle from EX in an in-order queue.
//  Drains one packet per cycle into the predictor's single update port.
//  After reset, and on request, it runs a clear sweep over every table index.
// PARAMETERS
//  h_width     14  BTB index width (hashed pc+bh)
//  k_width     14  CPHT index width (hashed pc)
//  ADDR_WIDTH  30  word-address width
//  DEPTH        4  queue entries; power of 2, >=2
//  IDX_W       14  clear-sweep index width = max(h_width,k_width)
//  PKT_W       2*ADDR_WIDTH+h_width+k_width+8 (96 with defaults)
//    pkt MSB->LSB: npc, ret_pc, bh_hashed, hashed, kind[2:0], taken, choice_real, choice_pdch[1:0], mis_pdc
// PORTS
//  clk          in   1      clock
//  rst          in   1      async reset, active-high
//  in0_valid    in   1      EX slot0 update (older)
//  in0_pkt      in   PKT_W  slot0 packet
//  in1_valid    in   1      EX slot1 update (younger)
//  in1_pkt      in   PKT_W  slot1 packet
//  in_ready     out  1      both slots may push this cycle
//  stall        in   1      predictor stalled; hold drain
//  init_req     in   1      pulse: request a table clear sweep
//  upd_en       out  1      update strobe to predictor
//  upd_pkt      out  PKT_W  head packet; all-zero when !upd_en
//  clr_en       out  1      table clear strobe
//  clr_idx      out  IDX_W  index being cleared
//  busy         out  1      state!=RUN or queue non-empty
// BEHAVIOUR
//  Reset values:
//   - state=INIT, count=0, rd/wr ptr=0, clr_idx=0.
//   - Outputs: in_ready=0, upd_en=0, upd_pkt=0, clr_en=1, busy=1.
//  FSM INIT -> RUN:
//   - INIT: clr_en=1, clr_idx increments 0..2^IDX_W-1, one index per cycle; stall is ignored.
//   - Exactly 2^IDX_W cycles, then RUN with clr_idx=0.
//  FSM RUN:
//   - init_req with count==0 -> INIT next cycle.
//   - init_req with count!=0 -> DRAIN.
//  FSM DRAIN:
//   - No pushes (in_ready=0); the queue keeps draining.
//   - Enters INIT on the cycle after the pop that empties the queue.
//  init_req during INIT or DRAIN is ignored; it is not queued.
//  Push:
//   - in_ready = (state==RUN) && (DEPTH-count >= 2), combinational.
//   - When in_ready=1, every valid slot is written; in0 goes before in1.
//   - in1 alone takes one entry.
//   - When in_ready=0, the valids are ignored; upstream holds.
//  Pop:
//   - upd_en = (state!=INIT) && count!=0 && !stall; the head is shown combinationally.
//   - A pop happens whenever upd_en=1.
//  Latency: a packet pushed in cycle N is at the earliest visible at upd_en in cycle N+1; there is no bypass.
//  Same-cycle push and pop: count_next = count + pushes - pop, in the range 0..DEPTH.
//  Pointers wrap modulo DEPTH.
//  Order: strict FIFO. in0 of cycle N precedes in1 of cycle N, which precedes anything from cycle N+1.
//  Async rst mid-sweep or mid-drain: queue contents are discarded and the sweep restarts at index 0.
// TESTING
//  1. Run with IDX_W=3. Release rst -> clr_en=1 for 8 cycles, clr_idx=0..7, then in_ready=1, busy=0.
//  2. RUN, push in0 pkt A (npc=0x100) and in1 pkt B (npc=0x200) in cycle N
//     -> upd_en N+1 with A, N+2 with B, then upd_en=0.
//  3. DEPTH=4, stall=1, push 2+2 -> count=4, in_ready=0.
//     in1-only valid while full is not accepted.
//     Drop stall -> 4 pops in order, in_ready=1 once count<=2.
//  4. stall toggled every cycle with a continuous single push
//     -> no loss, no duplication, and upd_en never asserts while stall=1.
//  5. init_req with count=3 -> DRAIN, in_ready=0, 3 pops, then INIT sweep of 8.
//     Pushes attempted during DRAIN are not accepted.
//  6. Assert rst during INIT at clr_idx=5 and during DRAIN with count=2
//     -> immediately count=0, upd_en=0, and the sweep restarts at 0.

Source files
------------

// File: rtl/bpu_update_sched.sv
// Update scheduler for the next-PC predictor tables: two-wide in-order push queue,
// single-port drain, and a full-index clear sweep after reset or on request.
module bpu_update_sched #(
    parameter int h_width    = 14,
    parameter int k_width    = 14,
    parameter int ADDR_WIDTH = 30,
    parameter int DEPTH      = 4,
    parameter int IDX_W      = 14,
    parameter int PKT_W      = 2*ADDR_WIDTH + h_width + k_width + 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in0_valid,
    input  logic [PKT_W-1:0] in0_pkt,
    input  logic             in1_valid,
    input  logic [PKT_W-1:0] in1_pkt,
    output logic             in_ready,
    input  logic             stall,
    input  logic             init_req,
    output logic             upd_en,
    output logic [PKT_W-1:0] upd_pkt,
    output logic             clr_en,
    output logic [IDX_W-1:0] clr_idx,
    output logic             busy
);
    localparam int NUM_LANES = 2;
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {INIT, RUN, DRAIN} state_t;

    state_t                           state, state_nxt;
    logic [PW-1:0]                    rd_ptr, wr_ptr;
    logic [CW-1:0]                    count, count_nxt;
    logic [PKT_W-1:0]                 mem [DEPTH];
    logic [NUM_LANES-1:0]             push;
    logic [NUM_LANES-1:0][PKT_W-1:0]  lane_pkt;
    logic [NUM_LANES-1:0][PW-1:0]     lane_addr;

    assign lane_pkt = {in1_pkt, in0_pkt};
    assign push     = {in1_valid, in0_valid} & {NUM_LANES{in_ready}};

    // Lane 1 lands behind lane 0 only when lane 0 actually pushes.
    assign lane_addr[0] = wr_ptr;
    assign lane_addr[1] = wr_ptr + PW'(push[0]);

    assign count_nxt = count + CW'(push[0]) + CW'(push[1]) - CW'(upd_en);
    assign upd_pkt   = upd_en ? mem[rd_ptr] : '0;

    always_comb begin
        state_nxt = state;
        in_ready  = (state == RUN) && (count <= CW'(DEPTH - 2));
        upd_en    = (state != INIT) && (count != '0) && !stall;
        clr_en    = (state == INIT);
        busy      = (state != RUN) || (count != '0);
        case (state)
            INIT:    if (clr_idx == '1) state_nxt = RUN;
            RUN:     if (init_req) state_nxt = (count == '0) ? INIT : DRAIN;
            DRAIN:   if (count_nxt == '0) state_nxt = INIT;
            default: state_nxt = INIT;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= INIT;
            count   <= '0;
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            clr_idx <= '0;
        end else begin
            state  <= state_nxt;
            count  <= count_nxt;
            rd_ptr <= rd_ptr + PW'(upd_en);
            wr_ptr <= wr_ptr + PW'(push[0]) + PW'(push[1]);
            // Wraps back to 0 on the final sweep cycle, ready for RUN.
            if (state == INIT) clr_idx <= clr_idx + IDX_W'(1);
        end
    end

    // Queue storage carries no reset; occupancy is governed by count alone.
    always_ff @(posedge clk) begin
        for (int l = 0; l < NUM_LANES; l++)
            if (push[l]) mem[lane_addr[l]] <= lane_pkt[l];
    end
endmodule

// File: tb/tb_bpu_update_sched.sv
// Directed bench for bpu_update_sched with an 8-entry clear sweep.
module tb_bpu_update_sched;
    localparam int PKT_W = 96;
    localparam int IDX_W = 3;

    logic             clk = 1'b0;
    logic             rst;
    logic             in0_valid, in1_valid, stall, init_req;
    logic [PKT_W-1:0] in0_pkt, in1_pkt;
    logic             in_ready, upd_en, clr_en, busy;
    logic [PKT_W-1:0] upd_pkt;
    logic [IDX_W-1:0] clr_idx;

    int tests = 0;
    int fails = 0;

    bpu_update_sched #(.IDX_W(IDX_W)) dut (
        .clk(clk), .rst(rst),
        .in0_valid(in0_valid), .in0_pkt(in0_pkt),
        .in1_valid(in1_valid), .in1_pkt(in1_pkt),
        .in_ready(in_ready), .stall(stall), .init_req(init_req),
        .upd_en(upd_en), .upd_pkt(upd_pkt),
        .clr_en(clr_en), .clr_idx(clr_idx), .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic logic [PKT_W-1:0] mk(input logic [29:0] npc, input logic [7:0] tag);
        return {npc, 58'h0, tag};
    endfunction

    task automatic chk(input string tag, input logic [PKT_W-1:0] obs, input logic [PKT_W-1:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        in0_valid = 0; in1_valid = 0; init_req = 0;
        in0_pkt = '0; in1_pkt = '0;
    endtask

    task automatic sweep(input string tag);
        for (int i = 0; i < 8; i++) begin
            chk({tag, "_clr_en"}, PKT_W'(clr_en), 1);
            chk({tag, "_clr_idx"}, PKT_W'(clr_idx), PKT_W'(i));
            chk({tag, "_upd_en"}, PKT_W'(upd_en), 0);
            tick();
        end
        chk({tag, "_run_clr_en"}, PKT_W'(clr_en), 0);
        chk({tag, "_run_clr_idx"}, PKT_W'(clr_idx), 0);
    endtask

    initial begin
        int n, p, c;
        logic acc;
        rst = 1; stall = 0; idle();
        #1;
        chk("rst_in_ready", PKT_W'(in_ready), 0);
        chk("rst_upd_en", PKT_W'(upd_en), 0);
        chk("rst_upd_pkt", upd_pkt, '0);
        chk("rst_clr_en", PKT_W'(clr_en), 1);
        chk("rst_clr_idx", PKT_W'(clr_idx), 0);
        chk("rst_busy", PKT_W'(busy), 1);
        tick(); tick();
        rst = 0;

        // Power-up sweep
        sweep("sw0");
        chk("sw0_in_ready", PKT_W'(in_ready), 1);
        chk("sw0_busy", PKT_W'(busy), 0);

        // Dual push, in-order drain, no bypass
        in0_valid = 1; in0_pkt = mk(30'h100, 8'hA);
        in1_valid = 1; in1_pkt = mk(30'h200, 8'hB);
        #1;
        chk("t2_ready", PKT_W'(in_ready), 1);
        chk("t2_nobypass", PKT_W'(upd_en), 0);
        tick(); idle(); #1;
        chk("t2_en_a", PKT_W'(upd_en), 1);
        chk("t2_pkt_a", upd_pkt, mk(30'h100, 8'hA));
        tick();
        chk("t2_en_b", PKT_W'(upd_en), 1);
        chk("t2_pkt_b", upd_pkt, mk(30'h200, 8'hB));
        tick();
        chk("t2_en_off", PKT_W'(upd_en), 0);
        chk("t2_pkt_zero", upd_pkt, '0);
        chk("t2_busy", PKT_W'(busy), 0);

        // Fill under stall, reject in1-only while full, then drain
        stall = 1;
        in0_valid = 1; in0_pkt = mk(30'h300, 8'hC);
        in1_valid = 1; in1_pkt = mk(30'h301, 8'hD);
        tick();
        in0_pkt = mk(30'h302, 8'hE); in1_pkt = mk(30'h303, 8'hF);
        #1;
        chk("t3_ready_c2", PKT_W'(in_ready), 1);
        tick(); idle();
        in1_valid = 1; in1_pkt = mk(30'h3FF, 8'h77);
        #1;
        chk("t3_full_ready", PKT_W'(in_ready), 0);
        chk("t3_stall_en", PKT_W'(upd_en), 0);
        tick(); idle(); stall = 0; #1;
        chk("t3_pkt_c", upd_pkt, mk(30'h300, 8'hC));
        chk("t3_ready_c4", PKT_W'(in_ready), 0);
        tick();
        chk("t3_pkt_d", upd_pkt, mk(30'h301, 8'hD));
        chk("t3_ready_c3", PKT_W'(in_ready), 0);
        tick();
        chk("t3_pkt_e", upd_pkt, mk(30'h302, 8'hE));
        chk("t3_ready_c2b", PKT_W'(in_ready), 1);
        tick();
        chk("t3_pkt_f", upd_pkt, mk(30'h303, 8'hF));
        tick();
        chk("t3_no_g", PKT_W'(upd_en), 0);
        chk("t3_busy", PKT_W'(busy), 0);

        // Toggling stall with a continuous single-slot stream
        n = 0; p = 0; c = 0;
        while (p < 8 && c < 60) begin
            stall = c[0];
            in0_valid = (n < 8);
            in0_pkt = mk(30'h400 + 30'(n), 8'(n));
            #1;
            acc = in_ready && in0_valid;
            chk("t4_en_vs_stall", PKT_W'(upd_en && stall), 0);
            if (upd_en) begin
                chk("t4_order", upd_pkt, mk(30'h400 + 30'(p), 8'(p)));
                p++;
            end
            tick();
            if (acc) n++;
            c++;
        end
        idle(); stall = 0; #1;
        chk("t4_pop_count", PKT_W'(p), 8);
        chk("t4_push_count", PKT_W'(n), 8);
        chk("t4_empty", PKT_W'(busy), 0);

        // init_req with three queued -> DRAIN, then sweep
        stall = 1;
        in0_valid = 1; in0_pkt = mk(30'h500, 8'h1);
        in1_valid = 1; in1_pkt = mk(30'h501, 8'h2);
        tick(); idle();
        in0_valid = 1; in0_pkt = mk(30'h502, 8'h3);
        tick(); idle();
        init_req = 1;
        tick(); idle(); stall = 0;
        in0_valid = 1; in0_pkt = mk(30'h5FF, 8'h99);
        #1;
        chk("t5_drain_ready", PKT_W'(in_ready), 0);
        chk("t5_pkt_h", upd_pkt, mk(30'h500, 8'h1));
        tick();
        chk("t5_pkt_i", upd_pkt, mk(30'h501, 8'h2));
        tick();
        chk("t5_ready_c1", PKT_W'(in_ready), 0);
        chk("t5_pkt_j", upd_pkt, mk(30'h502, 8'h3));
        tick(); idle(); #1;
        sweep("sw5");
        chk("t5_busy", PKT_W'(busy), 0);
        chk("t5_no_k", PKT_W'(upd_en), 0);

        // Reset mid-sweep at clr_idx=5
        init_req = 1;
        tick(); idle(); #1;
        for (int i = 0; i < 5; i++) tick();
        chk("t6_idx5", PKT_W'(clr_idx), 5);
        rst = 1; #1;
        chk("t6_rst_idx", PKT_W'(clr_idx), 0);
        chk("t6_rst_clr_en", PKT_W'(clr_en), 1);
        tick();
        rst = 0;
        sweep("sw6a");

        // Reset mid-drain with two queued
        stall = 1;
        in0_valid = 1; in0_pkt = mk(30'h600, 8'h5);
        in1_valid = 1; in1_pkt = mk(30'h601, 8'h6);
        tick(); idle();
        init_req = 1;
        tick(); idle(); #1;
        chk("t6_drain_ready", PKT_W'(in_ready), 0);
        chk("t6_drain_busy", PKT_W'(busy), 1);
        rst = 1; stall = 0; #1;
        chk("t6_rst_upd_en", PKT_W'(upd_en), 0);
        chk("t6_rst_clr_idx", PKT_W'(clr_idx), 0);
        chk("t6_rst_ready", PKT_W'(in_ready), 0);
        tick();
        rst = 0;
        sweep("sw6b");
        chk("t6_discarded", PKT_W'(busy), 0);
        chk("t6_no_pop", PKT_W'(upd_en), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
